telemetry_rx: RTL and testbench

- Bench-side and debug-side receiver for the eBike telemetry UART stream driven on TX.
- Deserializes the 8N1 byte stream and parses the fixed 8-byte telemetry frame.
- Presents the batt, curr and torque readings as parallel 12-bit registers with a one-cycle valid strobe.
- Used in full-chip testbenches to self-check the analog readings, and on the DE0 to drive a display and logging path.

---
 rtl/telemetry_rx.sv | 139 +++++++++++++
 tb/tb_telemetry_rx.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/telemetry_rx.sv
// telemetry_rx: 8N1 UART receiver and parser for the fixed 8-byte eBike telemetry frame.
// Frame layout is AA 55, then the high and low bytes of batt, curr and torque.
module telemetry_rx #(
    parameter int BAUD_DIV = 434,
    parameter int TMO_CYC  = 8680
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic [11:0] batt,
    output logic [11:0] curr,
    output logic [11:0] torque,
    output logic        vld,
    output logic        frm_err
);
    localparam int CW = $clog2(BAUD_DIV + 1);
    localparam int TW = $clog2(TMO_CYC + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} bst_t;
    typedef enum logic [2:0] {HDR1, HDR2, B_HI, B_LO, C_HI, C_LO, T_HI, T_LO} fst_t;

    bst_t        bst_q;
    fst_t        fst_q;
    logic        rx_m_q, rx_s_q, rx_p_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]  bit_q;
    logic [7:0]  sh_q;
    logic        byte_rdy_q, stop_err_q;
    logic [TW-1:0] tmo_q;
    logic [11:0] sb_q, sc_q, st_q;
    logic [11:0] batt_q, curr_q, torque_q;
    logic        vld_q, frm_err_q;
    logic        hi_bad;

    assign batt    = batt_q;
    assign curr    = curr_q;
    assign torque  = torque_q;
    assign vld     = vld_q;
    assign frm_err = frm_err_q;
    assign hi_bad  = sh_q[7:4] != 4'h0;

    // Counter expires when it reaches 1, so a load of N spaces samples N clocks apart.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m_q     <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_p_q     <= 1'b1;
            bst_q      <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            sh_q       <= '0;
            byte_rdy_q <= 1'b0;
            stop_err_q <= 1'b0;
        end else begin
            rx_m_q     <= RX;
            rx_s_q     <= rx_m_q;
            rx_p_q     <= rx_s_q;
            byte_rdy_q <= 1'b0;
            stop_err_q <= 1'b0;
            if (bst_q != IDLE) cnt_q <= cnt_q - 1'b1;
            case (bst_q)
                IDLE: if (rx_p_q && !rx_s_q) begin
                    bst_q <= START;
                    cnt_q <= CW'(BAUD_DIV / 2);
                end
                START: if (cnt_q == CW'(1)) begin
                    bst_q <= rx_s_q ? IDLE : DATA;
                    cnt_q <= CW'(BAUD_DIV);
                    bit_q <= '0;
                end
                DATA: if (cnt_q == CW'(1)) begin
                    sh_q  <= {rx_s_q, sh_q[7:1]};
                    cnt_q <= CW'(BAUD_DIV);
                    bit_q <= bit_q + 1'b1;
                    if (bit_q == 3'd7) bst_q <= STOP;
                end
                default: if (cnt_q == CW'(1)) begin
                    byte_rdy_q <= rx_s_q;
                    stop_err_q <= !rx_s_q;
                    bst_q      <= IDLE;
                end
            endcase
        end
    end

    // A byte arriving on the timeout clock wins over the timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fst_q     <= HDR1;
            tmo_q     <= '0;
            sb_q      <= '0;
            sc_q      <= '0;
            st_q      <= '0;
            batt_q    <= '0;
            curr_q    <= '0;
            torque_q  <= '0;
            vld_q     <= 1'b0;
            frm_err_q <= 1'b0;
        end else begin
            vld_q     <= 1'b0;
            frm_err_q <= 1'b0;
            tmo_q     <= (fst_q == HDR1 || byte_rdy_q) ? '0 : (bst_q == IDLE ? tmo_q + 1'b1 : tmo_q);
            if (stop_err_q) begin
                frm_err_q <= 1'b1;
                fst_q     <= HDR1;
            end else if (byte_rdy_q) begin
                case (fst_q)
                    HDR1: fst_q <= (sh_q == 8'hAA) ? HDR2 : HDR1;
                    HDR2: fst_q <= (sh_q == 8'h55) ? B_HI : (sh_q == 8'hAA) ? HDR2 : HDR1;
                    B_HI, C_HI, T_HI: begin
                        frm_err_q <= hi_bad;
                        fst_q     <= hi_bad ? HDR1 : fst_t'(fst_q + 3'd1);
                        if (!hi_bad && fst_q == B_HI) sb_q[11:8] <= sh_q[3:0];
                        if (!hi_bad && fst_q == C_HI) sc_q[11:8] <= sh_q[3:0];
                        if (!hi_bad && fst_q == T_HI) st_q[11:8] <= sh_q[3:0];
                    end
                    B_LO: begin
                        sb_q[7:0] <= sh_q;
                        fst_q     <= C_HI;
                    end
                    C_LO: begin
                        sc_q[7:0] <= sh_q;
                        fst_q     <= T_HI;
                    end
                    default: begin
                        st_q[7:0] <= sh_q;
                        batt_q    <= sb_q;
                        curr_q    <= sc_q;
                        torque_q  <= {st_q[11:8], sh_q};
                        vld_q     <= 1'b1;
                        fst_q     <= HDR1;
                    end
                endcase
            end else if (tmo_q == TW'(TMO_CYC)) begin
                fst_q <= HDR1;
            end
        end
    end
endmodule

// File: tb/tb_telemetry_rx.sv
// tb_telemetry_rx: scoreboard bench for telemetry_rx; frames push expected readings, vld pops them.
module tb_telemetry_rx;
    localparam int BD  = 32;
    localparam int TMO = 20 * BD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        RX  = 1'b1;
    logic [11:0] batt, curr, torque;
    logic        vld, frm_err;

    logic [35:0] exp_q[$];
    int n_chk = 0, n_pass = 0;
    int n_vld = 0, exp_vld = 0, n_err = 0, exp_err = 0;

    telemetry_rx #(.BAUD_DIV(BD), .TMO_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .RX(RX),
        .batt(batt), .curr(curr), .torque(torque),
        .vld(vld), .frm_err(frm_err)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (vld || frm_err) chk("vld_ferr_excl", 36'(vld & frm_err), 36'd0);
            if (frm_err) n_err++;
            if (vld) begin
                n_vld++;
                chk("vld_expected", 36'(exp_q.size() > 0), 36'd1);
                if (exp_q.size() > 0) chk("frame", {batt, curr, torque}, exp_q.pop_front());
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            RX = bits[i];
            repeat (BD) @(negedge clk);
        end
        RX = 1'b1;
        if (!stop) repeat (BD) @(negedge clk);
    endtask

    task automatic send_frame(input logic [11:0] b, input logic [11:0] c, input logic [11:0] t);
        exp_q.push_back({b, c, t});
        exp_vld++;
        send_byte(8'hAA);
        send_byte(8'h55);
        send_byte({4'h0, b[11:8]});
        send_byte(b[7:0]);
        send_byte({4'h0, c[11:8]});
        send_byte(c[7:0]);
        send_byte({4'h0, t[11:8]});
        send_byte(t[7:0]);
    endtask

    task automatic settle();
        for (int i = 0; i < 4 * BD && exp_q.size() != 0; i++) @(negedge clk);
        repeat (BD) @(negedge clk);
        chk("drain", 36'(exp_q.size()), 36'd0);
        chk("vld_count", 36'(n_vld), 36'(exp_vld));
        chk("ferr_count", 36'(n_err), 36'(exp_err));
    endtask

    initial begin
        #(60000 * 20);
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_outs", {batt, curr, torque}, 36'd0);
        chk("rst_strobes", 36'({vld, frm_err}), 36'd0);
        rst = 1'b0;
        repeat (BD) @(negedge clk);

        send_frame(12'hABC, 12'h123, 12'h7FF);
        settle();

        RX = 1'b0;
        repeat (10) @(negedge clk);
        RX = 1'b1;
        repeat (3 * BD) @(negedge clk);
        settle();
        chk("glitch_outs", {batt, curr, torque}, {12'hABC, 12'h123, 12'h7FF});

        send_byte(8'hAA);
        send_byte(8'h55);
        send_byte(8'h0A);
        exp_err++;
        send_byte(8'hBC, 1'b0);
        settle();
        chk("stop_err_outs", {batt, curr, torque}, {12'hABC, 12'h123, 12'h7FF});
        send_frame(12'h001, 12'h002, 12'h003);
        settle();

        send_byte(8'hAA);
        send_frame(12'h800, 12'h0A5, 12'h5A0);
        settle();
        chk("resync_batt", 36'(batt), 36'h800);

        send_byte(8'hAA);
        send_byte(8'h55);
        send_byte(8'h01);
        send_byte(8'h23);
        exp_err++;
        send_byte(8'h1F);
        settle();
        chk("hi_err_outs", {batt, curr, torque}, {12'h800, 12'h0A5, 12'h5A0});

        send_byte(8'hAA);
        send_byte(8'h55);
        send_byte(8'h01);
        send_byte(8'h23);
        repeat (TMO + 60) @(negedge clk);
        send_frame(12'h321, 12'h654, 12'h456);
        settle();
        chk("tmo_torque", 36'(torque), 36'h456);

        send_byte(8'hAA);
        send_byte(8'h55);
        send_byte(8'h0F);
        send_byte(8'hFF);
        send_byte(8'h01);
        RX = 1'b0;
        repeat (3 * BD) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        RX = 1'b1;
        chk("midrst_outs", {batt, curr, torque}, 36'd0);
        chk("midrst_strobes", 36'({vld, frm_err}), 36'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2 * BD) @(negedge clk);
        chk("post_rst_outs", {batt, curr, torque}, 36'd0);
        send_frame(12'h135, 12'h246, 12'h357);
        settle();
        chk("clean_outs", {batt, curr, torque}, {12'h135, 12'h246, 12'h357});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
